// File: rtl/rns_addsub_ctrl_pkg.sv
// Shared definitions for the RNS residue-channel add/subtract sequencer:
// FSM state encoding, default residue width and the channel moduli.
package rns_addsub_ctrl_pkg;

  // Sequencer states: accept, select B/complement, add, reduce, present.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SEL  = 3'd1,
    ST_ADD  = 3'd2,
    ST_RED  = 3'd3,
    ST_OUT  = 3'd4
  } state_e;

  // Default residue bit width (also the select mux datapath width).
  localparam int DEFAULT_WIDTH = 4;

  // Moduli used by the residue channels of the RNS datapath.
  localparam int MOD_7  = 7;
  localparam int MOD_15 = 15;
  localparam int MOD_16 = 16;

endpackage

// File: rtl/rns_addsub_ctrl_mux.sv
// 2:1 select mux feeding the channel adder: i0 when s0=0, i1 when s0=1.
module rns_addsub_ctrl_mux #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic             s0,
  output logic [WIDTH-1:0] y
);

  // Pure combinational selection.
  always_comb begin
    y = s0 ? i1 : i0;
  end

endmodule

// File: rtl/rns_addsub_ctrl.sv
// One residue channel of the RNS add/subtract datapath.
// Accepts (a, b, op), forms the additive inverse of b, selects b or its
// inverse through the 2:1 mux, adds and reduces modulo MOD, then holds
// the result until the consumer takes it. One operation in flight.
module rns_addsub_ctrl
  import rns_addsub_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int MOD   = MOD_7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic             out_err,
  output logic             mux_sel,
  output logic             busy
);

  // The channel modulus can equal 2^WIDTH, so range checks use one extra
  // bit. The low WIDTH bits alone are enough for the subtractions, whose
  // true results always fit in WIDTH bits (MOD-b for b>=1, sum-MOD when
  // sum>=MOD).
  localparam logic [WIDTH:0]   MOD_W  = (WIDTH+1)'(MOD);
  localparam logic [WIDTH-1:0] MOD_LO = WIDTH'(MOD);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             op_q, op_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] comp_q, comp_d;
  logic             mux_sel_q, mux_sel_d;
  logic [WIDTH:0]   sum_q, sum_d;
  logic [WIDTH-1:0] out_res_q, out_res_d;
  logic             out_err_q, out_err_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] mux_y;

  // The mux select comes from a register, so SEL registers the complement
  // and the select together; the mux output is then consumed by ADD once
  // the select has settled to the latched opcode.
  rns_addsub_ctrl_mux #(
    .WIDTH (WIDTH)
  ) u_mux_2_1 (
    .i0 (b_q),
    .i1 (comp_q),
    .s0 (mux_sel_q),
    .y  (mux_y)
  );

  // Next-state and datapath computation for every sequencer step.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    err_d     = err_q;
    comp_d    = comp_q;
    mux_sel_d = mux_sel_q;
    sum_d     = sum_q;
    out_res_d = out_res_q;
    out_err_d = out_err_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d     = in_a;
          b_d     = in_b;
          op_d    = in_op;
          err_d   = ({1'b0, in_a} >= MOD_W) || ({1'b0, in_b} >= MOD_W);
          state_d = ST_SEL;
        end
      end
      ST_SEL: begin
        // Inverse of zero is zero, never MOD.
        comp_d    = (b_q == '0) ? '0 : (MOD_LO - b_q);
        mux_sel_d = op_q;
        state_d   = ST_ADD;
      end
      ST_ADD: begin
        sum_d   = {1'b0, a_q} + {1'b0, mux_y};
        state_d = ST_RED;
      end
      ST_RED: begin
        if (err_q) begin
          out_res_d = '0;
        end else if (sum_q >= MOD_W) begin
          out_res_d = sum_q[WIDTH-1:0] - MOD_LO;
        end else begin
          out_res_d = sum_q[WIDTH-1:0];
        end
        out_err_d = err_q;
        state_d   = ST_OUT;
      end
      ST_OUT: begin
        if (out_valid_q && out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Handshake outputs are registered from the next state. out_valid
    // rises on the second OUT cycle, which places it four edges after
    // the accepting edge, and drops on the edge the result is taken.
    out_valid_d = (state_q == ST_OUT) && (state_d == ST_OUT);
    in_ready_d  = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
  end

  // Single state register for the sequencer, datapath and outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= 1'b0;
      err_q       <= 1'b0;
      comp_q      <= '0;
      mux_sel_q   <= 1'b0;
      sum_q       <= '0;
      out_res_q   <= '0;
      out_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      err_q       <= err_d;
      comp_q      <= comp_d;
      mux_sel_q   <= mux_sel_d;
      sum_q       <= sum_d;
      out_res_q   <= out_res_d;
      out_err_q   <= out_err_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_res   = out_res_q;
  assign out_err   = out_err_q;
  assign mux_sel   = mux_sel_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_rns_addsub_ctrl.sv
// Directed bench for rns_addsub_ctrl: a MOD=7 channel for the directed
// cases and a MOD=15 channel for the exhaustive add/subtract sweep.
module tb_rns_addsub_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // Signals of the modulus-7 instance
  logic       in_valid = 1'b0, in_op = 1'b0, out_ready = 1'b0;
  logic [3:0] in_a = '0, in_b = '0;
  logic       in_ready, out_valid, out_err, mux_sel, busy;
  logic [3:0] out_res;

  // Signals of the modulus-15 instance
  logic       s_in_valid = 1'b0, s_in_op = 1'b0, s_out_ready = 1'b1;
  logic [3:0] s_in_a = '0, s_in_b = '0;
  logic       s_in_ready, s_out_valid, s_out_err, s_mux_sel, s_busy;
  logic [3:0] s_out_res;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rns_addsub_ctrl #(.WIDTH(4), .MOD(7)) dut7 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .out_err(out_err),
    .mux_sel(mux_sel), .busy(busy)
  );

  rns_addsub_ctrl #(.WIDTH(4), .MOD(15)) dut15 (
    .clk(clk), .rst(rst),
    .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_a(s_in_a), .in_b(s_in_b), .in_op(s_in_op),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_res(s_out_res), .out_err(s_out_err),
    .mux_sel(s_mux_sel), .busy(s_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op to the MOD=7 channel; returns when out_valid is seen
  // (or the bound expires) and reports the edge count since acceptance.
  task automatic op7(input logic [3:0] a, input logic [3:0] b, input logic op,
                     output int lat);
    in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
    tick();                       // accepting edge
    in_valid = 1'b0;
    in_a = ~a; in_b = ~b; in_op = ~op;  // later changes must not matter
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic take7();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    int exp_r;

    // Reset
    tick(); tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_res", out_res, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_mux_sel", mux_sel, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    tick();
    chk("idle_in_ready", in_ready, 1);

    // 5+4 mod 7 = 2
    op7(4'd5, 4'd4, 1'b0, lat);
    $display("op 5+4 mod7 res=%0d err=%0d lat=%0d", out_res, out_err, lat);
    chk("add_lat", lat, 4);
    chk("add_res", out_res, 2);
    chk("add_err", out_err, 0);
    chk("add_mux_sel", mux_sel, 0);
    chk("add_in_ready_out", in_ready, 0);
    chk("add_busy", busy, 1);
    take7();
    chk("add_in_ready_after", in_ready, 1);
    chk("add_valid_after", out_valid, 0);

    // 2-5 mod 7 = 4 (complement of 5 is 2)
    op7(4'd2, 4'd5, 1'b1, lat);
    $display("op 2-5 mod7 res=%0d err=%0d lat=%0d", out_res, out_err, lat);
    chk("sub_lat", lat, 4);
    chk("sub_res", out_res, 4);
    chk("sub_mux_sel", mux_sel, 1);
    take7();

    // 3-0 mod 7 = 3 (complement of 0 is 0)
    op7(4'd3, 4'd0, 1'b1, lat);
    $display("op 3-0 mod7 res=%0d err=%0d lat=%0d", out_res, out_err, lat);
    chk("subzero_res", out_res, 3);
    chk("subzero_err", out_err, 0);
    take7();

    // Back-pressure: 4+6 mod 7 = 3 held for 10 cycles, stray input ignored
    op7(4'd4, 4'd6, 1'b0, lat);
    $display("op 4+6 mod7 res=%0d err=%0d lat=%0d", out_res, out_err, lat);
    chk("bp_res0", out_res, 3);
    in_a = 4'd1; in_b = 4'd1; in_op = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_res_hold", out_res, 3);
      chk("bp_valid_hold", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    take7();
    chk("bp_in_ready_after", in_ready, 1);
    tick(); tick(); tick(); tick(); tick();
    chk("bp_stray_ignored_valid", out_valid, 0);
    chk("bp_stray_ignored_busy", busy, 0);

    // Range error: a=9 >= 7
    op7(4'd9, 4'd1, 1'b0, lat);
    $display("op 9+1 mod7 res=%0d err=%0d lat=%0d", out_res, out_err, lat);
    chk("err_lat", lat, 4);
    chk("err_flag", out_err, 1);
    chk("err_res", out_res, 0);
    take7();

    // Reset while in ADD
    in_a = 4'd1; in_b = 4'd2; in_op = 1'b1; in_valid = 1'b1;
    tick();                // accept -> SEL
    in_valid = 1'b0;
    tick();                // -> ADD
    rst = 1'b1;
    tick();
    rst = 1'b0;
    $display("reset in ADD: in_ready=%0d out_valid=%0d busy=%0d", in_ready, out_valid, busy);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_mux_sel", mux_sel, 0);
    tick(); tick(); tick(); tick(); tick();
    chk("mid_rst_no_partial", out_valid, 0);
    op7(4'd6, 4'd6, 1'b0, lat);
    $display("op 6+6 mod7 res=%0d err=%0d lat=%0d", out_res, out_err, lat);
    chk("post_rst_res", out_res, 5);
    chk("post_rst_lat", lat, 4);
    take7();

    // Exhaustive MOD=15 sweep, consumer always ready
    for (int op = 0; op < 2; op++) begin
      for (int a = 0; a < 15; a++) begin
        for (int b = 0; b < 15; b++) begin
          int n;
          exp_r = (op == 0) ? (a + b) % 15 : (a - b + 15) % 15;
          s_in_a = 4'(a); s_in_b = 4'(b); s_in_op = 1'(op); s_in_valid = 1'b1;
          tick();
          s_in_valid = 1'b0;
          n = 0;
          while (!s_out_valid && n < 20) begin
            tick();
            n++;
          end
          $display("sweep mod15 a=%0d b=%0d op=%0d res=%0d", a, b, op, s_out_res);
          chk("sweep_res", s_out_res, exp_r);
          tick();   // result taken, back to IDLE
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
